// File: rtl/id_issue_ctrl.sv
// rtl/id_issue_ctrl.sv - decode-stage issue/stall/exception controller with RAW scoreboard
// Optional build macro UOP_FWD_EN: only load-use against the newest tracker entry stalls.
module id_issue_ctrl #(
  parameter int          DEPTH      = 3,
  parameter logic [15:0] EXC_VECTOR = 16'h0002
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        inst_valid_p2,
  input  logic [15:0] pc_p2,
  input  logic [2:0]  rs_index,
  input  logic [2:0]  rt_index,
  input  logic        rs_used_p2,
  input  logic        rt_used_p2,
  input  logic [2:0]  dest_reg_p2,
  input  logic        reg_write_valid_p2,
  input  logic        load_p2,
  input  logic        halt_p2,
  input  logic        illegal_op_p2,
  input  logic        return_execution_p2,
  input  logic        redirect_ex,
  output logic        stall_ifid_p2,
  output logic        issue_valid_idix_p2,
  output logic        exc_redirect_valid,
  output logic [15:0] exc_redirect_pc,
  output logic [15:0] epc,
  output logic        halted
);

  typedef enum logic [2:0] {
    S_RUN,
    S_DRAIN_HALT,
    S_HALTED,
    S_DRAIN_EXC,
    S_EXC_REDIR
  } state_t;

  state_t           r_state;
  logic [DEPTH-1:0] r_trk_valid;
  logic [DEPTH-1:0] r_trk_load;
  logic [2:0]       r_trk_reg [DEPTH];
  logic [15:0]      r_epc;

  logic w_hazard;
  logic w_drain_done;
  logic w_push;
  logic w_stall;
  logic w_issue;
  logic w_redir;
  logic w_unused;

`ifdef UOP_FWD_EN
  always_comb begin
    w_hazard = r_trk_valid[0] && r_trk_load[0] &&
               ((rs_used_p2 && (rs_index == r_trk_reg[0])) ||
                (rt_used_p2 && (rt_index == r_trk_reg[0])));
  end
  assign w_unused = ^{r_trk_valid[DEPTH-1], r_trk_reg[DEPTH-1], r_trk_load[DEPTH-1]};
`else
  always_comb begin
    w_hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (r_trk_valid[i] && ((rs_used_p2 && (rs_index == r_trk_reg[i])) ||
                             (rt_used_p2 && (rt_index == r_trk_reg[i]))))
        w_hazard = 1'b1;
    end
  end
  assign w_unused = r_trk_load[DEPTH-1];
`endif

  // Drains only push bubbles, so the tracker is empty after this edge once
  // every entry except the one being discarded is already invalid.
  always_comb begin
    w_drain_done = 1'b1;
    for (int i = 0; i < DEPTH-1; i++) begin
      if (r_trk_valid[i]) w_drain_done = 1'b0;
    end
  end

  always_comb begin
    w_stall = 1'b0;
    w_issue = 1'b0;
    w_redir = 1'b0;
    case (r_state)
      S_RUN: begin
        if (redirect_ex || !inst_valid_p2) begin
          w_stall = 1'b0;
        end else if (w_hazard || halt_p2 || illegal_op_p2) begin
          w_stall = 1'b1;
        end else if (return_execution_p2) begin
          w_redir = 1'b1;
        end else begin
          w_issue = 1'b1;
        end
      end
      S_DRAIN_HALT, S_HALTED, S_DRAIN_EXC: w_stall = 1'b1;
      S_EXC_REDIR:                         w_redir = 1'b1;
      default:                             w_stall = 1'b0;
    endcase
  end

  assign w_push              = w_issue && reg_write_valid_p2;
  assign stall_ifid_p2       = w_stall;
  assign issue_valid_idix_p2 = w_issue;
  assign exc_redirect_valid  = w_redir;
  assign exc_redirect_pc     = (r_state == S_EXC_REDIR) ? EXC_VECTOR : r_epc;
  assign epc                 = r_epc;
  assign halted              = (r_state == S_HALTED);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_RUN;
      r_trk_valid <= '0;
      r_trk_load  <= '0;
      r_epc       <= 16'h0000;
      for (int i = 0; i < DEPTH; i++) r_trk_reg[i] <= 3'd0;
    end else begin
      for (int i = DEPTH-1; i > 0; i--) begin
        r_trk_valid[i] <= r_trk_valid[i-1];
        r_trk_load[i]  <= r_trk_load[i-1];
        r_trk_reg[i]   <= r_trk_reg[i-1];
      end
      r_trk_valid[0] <= w_push;
      r_trk_load[0]  <= w_push && load_p2;
      r_trk_reg[0]   <= dest_reg_p2;

      case (r_state)
        S_RUN: begin
          if (!redirect_ex && inst_valid_p2 && !w_hazard) begin
            if (halt_p2) begin
              r_state <= S_DRAIN_HALT;
            end else if (illegal_op_p2) begin
              r_epc   <= pc_p2 + 16'd2;
              r_state <= S_DRAIN_EXC;
            end
          end
        end
        S_DRAIN_HALT: if (w_drain_done) r_state <= S_HALTED;
        S_HALTED:     r_state <= S_HALTED;
        S_DRAIN_EXC:  if (w_drain_done) r_state <= S_EXC_REDIR;
        S_EXC_REDIR:  r_state <= S_RUN;
        default:      r_state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_id_issue_ctrl.sv
// tb/tb_id_issue_ctrl.sv - scoreboard bench for id_issue_ctrl
module tb_id_issue_ctrl;

`ifdef UOP_FWD_EN
  localparam int ADD_STALLS  = 0;
  localparam int LD_STALLS   = 1;
  localparam int LATE_STALLS = 0;
`else
  localparam int ADD_STALLS  = 3;
  localparam int LD_STALLS   = 3;
  localparam int LATE_STALLS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid_p2;
  logic [15:0] pc_p2;
  logic [2:0]  rs_index, rt_index, dest_reg_p2;
  logic        rs_used_p2, rt_used_p2, reg_write_valid_p2, load_p2;
  logic        halt_p2, illegal_op_p2, return_execution_p2, redirect_ex;
  logic        stall_ifid_p2, issue_valid_idix_p2, exc_redirect_valid, halted;
  logic [15:0] exc_redirect_pc, epc;

  typedef struct {
    logic        stall;
    logic        issue;
    logic        rv;
    logic [15:0] rpc;
    logic        halted;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] m_epc = 16'h0000;

  always #5 clk = ~clk;

  id_issue_ctrl dut (
    .clk(clk), .rst(rst), .inst_valid_p2(inst_valid_p2), .pc_p2(pc_p2),
    .rs_index(rs_index), .rt_index(rt_index), .rs_used_p2(rs_used_p2), .rt_used_p2(rt_used_p2),
    .dest_reg_p2(dest_reg_p2), .reg_write_valid_p2(reg_write_valid_p2), .load_p2(load_p2),
    .halt_p2(halt_p2), .illegal_op_p2(illegal_op_p2), .return_execution_p2(return_execution_p2),
    .redirect_ex(redirect_ex), .stall_ifid_p2(stall_ifid_p2), .issue_valid_idix_p2(issue_valid_idix_p2),
    .exc_redirect_valid(exc_redirect_valid), .exc_redirect_pc(exc_redirect_pc), .epc(epc), .halted(halted)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ex(input logic s, input logic i, input logic rv,
                              input logic [15:0] rpc, input logic h);
    exp_t e;
    e.stall = s; e.issue = i; e.rv = rv; e.rpc = rpc; e.halted = h;
    return e;
  endfunction

  task automatic clr();
    inst_valid_p2 = 0; pc_p2 = 16'h0000; rs_index = 0; rt_index = 0;
    rs_used_p2 = 0; rt_used_p2 = 0; dest_reg_p2 = 0; reg_write_valid_p2 = 0;
    load_p2 = 0; halt_p2 = 0; illegal_op_p2 = 0; return_execution_p2 = 0; redirect_ex = 0;
  endtask

  task automatic step(input string tag, input exp_t e);
    exp_t got;
    sb.push_back(e);
    #1;
    got = sb.pop_front();
    check({tag, ".stall"},  stall_ifid_p2,       got.stall);
    check({tag, ".issue"},  issue_valid_idix_p2, got.issue);
    check({tag, ".rv"},     exc_redirect_valid,  got.rv);
    check({tag, ".rpc"},    exc_redirect_pc,     got.rpc);
    check({tag, ".halted"}, halted,              got.halted);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input int n);
    clr();
    for (int k = 0; k < n; k++) step(tag, ex(0, 0, 0, m_epc, 0));
  endtask

  task automatic write_issue(input string tag, input logic [2:0] rd, input logic ld);
    clr(); inst_valid_p2 = 1; dest_reg_p2 = rd; reg_write_valid_p2 = 1; load_p2 = ld;
    step(tag, ex(0, 1, 0, m_epc, 0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    clr();
    rst = 1;
    @(negedge clk);
    inst_valid_p2 = 1;
    step("rst_state", ex(0, 1, 0, 16'h0000, 0));
    check("rst_epc", epc, 16'h0000);
    rst = 0;

    // dependent ADD behind ADDI writing R3
    write_issue("addi", 3'd3, 1'b0);
    clr(); inst_valid_p2 = 1; rs_index = 3; rs_used_p2 = 1;
    for (int k = 0; k < ADD_STALLS; k++) step("add_stall", ex(1, 0, 0, m_epc, 0));
    step("add_issue", ex(0, 1, 0, m_epc, 0));
    idle("idle1", 3);

    // load-use through rt
    write_issue("ld", 3'd2, 1'b1);
    clr(); inst_valid_p2 = 1; rt_index = 2; rt_used_p2 = 1;
    for (int k = 0; k < LD_STALLS; k++) step("sub_stall", ex(1, 0, 0, m_epc, 0));
    step("sub_issue", ex(0, 1, 0, m_epc, 0));
    idle("idle2", 3);

    // writer sitting in the oldest entry still blocks (no-forward build)
    write_issue("late_wr", 3'd4, 1'b0);
    idle("late_gap", 2);
    clr(); inst_valid_p2 = 1; rs_index = 4; rs_used_p2 = 1;
    for (int k = 0; k < LATE_STALLS; k++) step("late_stall", ex(1, 0, 0, m_epc, 0));
    step("late_issue", ex(0, 1, 0, m_epc, 0));
    idle("idle3", 3);

    // tracker fully empty after three bubbles, R0 included as ordinary source
    write_issue("r0_wr", 3'd0, 1'b0);
    idle("empty_gap", 3);
    clr(); inst_valid_p2 = 1; rs_index = 0; rs_used_p2 = 1; rt_index = 0; rt_used_p2 = 1;
    step("empty_issue", ex(0, 1, 0, m_epc, 0));

    // IllegalOp at 16'hFFFF wraps epc
    clr(); inst_valid_p2 = 1; pc_p2 = 16'hFFFF; illegal_op_p2 = 1;
    step("ill_wrap", ex(1, 0, 0, m_epc, 0));
    m_epc = 16'h0001;
    clr();
    step("drain_exc", ex(1, 0, 0, m_epc, 0));
    step("exc_redir", ex(0, 0, 1, 16'h0002, 0));
    check("epc_wrap", epc, 16'h0001);
    step("run_after_exc", ex(0, 0, 0, m_epc, 0));

    // redirect_ex beats halt and hazard
    write_issue("rex_wr", 3'd5, 1'b0);
    clr(); inst_valid_p2 = 1; rs_index = 5; rs_used_p2 = 1; halt_p2 = 1; redirect_ex = 1;
    step("rex", ex(0, 0, 0, m_epc, 0));
    idle("rex_run", 3);

    // IllegalOp at 16'h0040 behind one writer, then RTI
    write_issue("exc_wr", 3'd6, 1'b0);
    clr(); inst_valid_p2 = 1; pc_p2 = 16'h0040; illegal_op_p2 = 1;
    step("ill", ex(1, 0, 0, m_epc, 0));
    m_epc = 16'h0042;
    clr();
    for (int k = 0; k < 2; k++) step("drain_exc2", ex(1, 0, 0, m_epc, 0));
    step("exc_redir2", ex(0, 0, 1, 16'h0002, 0));
    check("epc_0042", epc, 16'h0042);
    idle("run2", 1);
    clr(); inst_valid_p2 = 1; return_execution_p2 = 1;
    step("rti", ex(0, 0, 1, 16'h0042, 0));
    idle("post_rti", 1);

    // HALT behind two writers
    write_issue("h_wr1", 3'd1, 1'b0);
    write_issue("h_wr2", 3'd2, 1'b0);
    clr(); inst_valid_p2 = 1; halt_p2 = 1;
    step("halt", ex(1, 0, 0, m_epc, 0));
    clr();
    for (int k = 0; k < 2; k++) step("drain_halt", ex(1, 0, 0, m_epc, 0));
    for (int k = 0; k < 10; k++) begin
      clr(); inst_valid_p2 = 1; dest_reg_p2 = 7; reg_write_valid_p2 = 1; redirect_ex = (k == 3);
      step("halted", ex(1, 0, 0, m_epc, 1));
    end
    clr();
    rst = 1;
    @(negedge clk);
    rst = 0;
    m_epc = 16'h0000;
    step("post_rst", ex(0, 0, 0, m_epc, 0));
    check("post_rst_epc", epc, 16'h0000);
    clr(); inst_valid_p2 = 1;
    step("post_rst_issue", ex(0, 1, 0, m_epc, 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/id_issue_ctrl.md
# id_issue_ctrl

Decode-stage issue controller between the IF/ID register and the ID/EX register. Each cycle it decides whether the decoded instruction issues, stalls, or is squashed. It tracks in-flight register writes in a shift-register scoreboard to detect RAW hazards, and sequences halt, IllegalOp exception entry and return-from-exception through a small state machine. Its outputs hold the PC/IF-ID register, gate the ID/EX valid bits, and drive the exception redirect into fetch.

## Interface
- `DEPTH`, 3: in-flight window tracked (EX, MEM, WB stages).
- `EXC_VECTOR`, 16'h0002: fetch target on IllegalOp.
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `inst_valid_p2` in 1: IF/ID holds a real instruction.
- `pc_p2` in 16: PC of the decode instruction.
- `rs_index`, `rt_index` in 3 each: source registers.
- `rs_used_p2`, `rt_used_p2` in 1 each: the source is actually read.
- `dest_reg_p2` in 3: destination register.
- `reg_write_valid_p2` in 1: the instruction writes `dest_reg_p2`.
- `load_p2` in 1: the instruction is LD.
- `halt_p2`, `illegal_op_p2`, `return_execution_p2` in 1 each: decoded HALT, IllegalOp, RTI.
- `redirect_ex` in 1: a taken jump/branch resolved in EX this cycle.
- `stall_ifid_p2` out 1: hold PC and IF/ID.
- `issue_valid_idix_p2` out 1: the ID/EX capture is a valid instruction (0 = bubble).
- `exc_redirect_valid` out 1: fetch must load `exc_redirect_pc`.
- `exc_redirect_pc` out 16: redirect target.
- `epc` out 16: saved exception PC.
- `halted` out 1: the core is stopped.

## Operation
- **Tracker:** DEPTH entries of {valid, reg[2:0], load}. It shifts every cycle, because the downstream pipe never stalls.
  - Entry 0 loads {1, `dest_reg_p2`, `load_p2`} when the instruction issues with `reg_write_valid_p2`=1; otherwise it loads a bubble.
  - The entry shifted out of DEPTH-1 is discarded.
- **Hazard:** a used source (`rs_used_p2` & `rs_index`, or `rt_used_p2` & `rt_index`) matches a valid tracker entry. R0 is an ordinary register (no hardwired zero).
- **States:**
  - RUN: normal operation.
  - DRAIN_HALT: waiting for the pipe to empty before stopping.
  - HALTED: stopped.
  - DRAIN_EXC: waiting for the pipe to empty before exception entry.
  - EXC_REDIR: one-cycle redirect to `EXC_VECTOR`.
- **RUN priority, highest first:**
  1. `redirect_ex`: issue=0, stall=0. The decode instruction is squashed and halt/illegal/RTI are ignored.
  2. `!inst_valid_p2`: issue=0, stall=0.
  3. hazard: stall=1, issue=0.
  4. `halt_p2`: issue=0, stall=1, go to DRAIN_HALT.
  5. `illegal_op_p2`: issue=0, stall=1, `epc` <= `pc_p2`+2 (16-bit wrap), go to DRAIN_EXC.
  6. `return_execution_p2`: issue=0, stall=0, `exc_redirect_valid`=1, `exc_redirect_pc`=`epc`. Stay in RUN.
  7. Otherwise: issue=1, stall=0.
- **DRAIN_HALT:** stall=1, issue=0. When all tracker entries are invalid, go to HALTED.
- **HALTED:** stall=1, issue=0, `halted`=1. It is sticky until `rst`.
- **DRAIN_EXC:** stall=1, issue=0. When the tracker is empty, go to EXC_REDIR.
- **EXC_REDIR:** `exc_redirect_valid`=1, `exc_redirect_pc`=`EXC_VECTOR`, stall=0, issue=0. Go to RUN next cycle.
- `redirect_ex` is ignored outside RUN.
- When `exc_redirect_valid`=0, `exc_redirect_pc`=`epc`.

## Timing
- Stall, issue and redirect outputs are combinational from the p2 inputs plus registered state/tracker. They have zero latency and must settle in the same cycle.
- Tracker, state and `epc` are registered on posedge `clk`.
- Without forwarding, a dependent instruction directly behind a writer stalls exactly DEPTH cycles (3 by default).
- Drain length is the number of cycles until the youngest valid entry shifts out, at most DEPTH.
- **Reset (synchronous, `rst`=1 at posedge):**
  - state=RUN, all tracker entries invalid, `epc`=0.
  - `halted`=0, `exc_redirect_valid`=0, `stall_ifid_p2`=0.
  - `issue_valid_idix_p2` follows `inst_valid_p2`.
  - Reset mid-drain or in HALTED returns to RUN and empties the tracker.
- Issue and the tracker shift in the same cycle: a hazard check sees only entries that already existed at the start of the cycle.

## Configuration
- **`UOP_FWD_EN` defined:** a hazard exists only when a used source matches tracker entry 0, that entry is valid, and its load flag is set (load-use). A load-use stalls exactly 1 cycle. All other RAW dependences issue without stalling, relying on forwarding.
- **`UOP_FWD_EN` undefined:** hazard against any valid entry 0..DEPTH-1, as described in Operation. Drain behaviour is unchanged in both builds.

## Test plan
- **ADDI then dependent ADD, no fwd:** ADDI (`dest_reg_p2`=3, write) issues, then ADD with `rs_index`=3 -> `stall_ifid_p2`=1 for 3 cycles, then issue=1. With `UOP_FWD_EN`: 0 stall cycles.
- **LD then use, `UOP_FWD_EN`:** LD writing R2, then SUB reading R2 via `rt_index` -> exactly 1 stall cycle.
- **HALT behind two writers:** drain stall for 2 cycles, then `halted`=1 held for 10 cycles. Assert `rst` -> `halted`=0 and stall=0 on the next cycle.
- **IllegalOp at `pc_p2`=16'h0040:** `epc`=16'h0042. After drain, `exc_redirect_valid`=1 for one cycle with `exc_redirect_pc`=16'h0002. A later RTI -> redirect to 16'h0042 in the same cycle.
- **`redirect_ex` coincident with `halt_p2` and a hazard:** issue=0, stall=0, state stays RUN, no halt.
- **Tracker empties with no new writes:** 3 cycles after the last write-issue, every register is hazard-free. `pc_p2`=16'hFFFF IllegalOp -> `epc`=16'h0001 (wrap).
